bcd_serial_add_ctrl: RTL

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_serial_add_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: latches two packed-BCD operands on start, adds one
// decimal digit per clock from digit 0 upward, then pulses done for one cycle.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic          c;
  logic [IW-1:0] idx;

  logic [3:0]    ad;
  logic [3:0]    bd;
  logic [4:0]    t;
  logic [3:0]    rdig;
  logic          nc;
  logic          bad;

  // One decimal digit of the running addition; non-BCD digits follow the same
  // +6 correction rule, with no saturation.
  always_comb begin
    ad   = ra[{idx, 2'b00} +: 4];
    bd   = rb[{idx, 2'b00} +: 4];
    t    = 5'(ad) + 5'(bd) + 5'(c);
    rdig = t[3:0];
    nc   = 1'b0;
    if (t > 5'd9) begin
      rdig = t[3:0] + 4'd6;
      nc   = 1'b1;
    end
  end

  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((ra[4*i +: 4] > 4'd9) || (rb[4*i +: 4] > 4'd9))
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      c     <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            state <= ADD;
          end
        end
        ADD: begin
          sum[{idx, 2'b00} +: 4] <= rdig;
          c                      <= nc;
          if (idx == LAST) begin
            cout  <= nc;
            err   <= bad;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ADD) || (state == DONE);
  assign done = (state == DONE);

endmodule
